// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// RV32M funct3 codes, FSM state encoding and the op bus width.
package ex_muldiv_pkg;

  localparam int MD_OP_BUS = 3;

  localparam logic [MD_OP_BUS-1:0] MD_MUL    = 3'b000;
  localparam logic [MD_OP_BUS-1:0] MD_MULH   = 3'b001;
  localparam logic [MD_OP_BUS-1:0] MD_MULHSU = 3'b010;
  localparam logic [MD_OP_BUS-1:0] MD_MULHU  = 3'b011;
  localparam logic [MD_OP_BUS-1:0] MD_DIV    = 3'b100;
  localparam logic [MD_OP_BUS-1:0] MD_DIVU   = 3'b101;
  localparam logic [MD_OP_BUS-1:0] MD_REM    = 3'b110;
  localparam logic [MD_OP_BUS-1:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input logic [MD_OP_BUS-1:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic rs2_signed(input logic [MD_OP_BUS-1:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_md_divider.sv
// Restoring unsigned divider: one quotient bit per step, XLEN steps.
// Exposes the post-step quotient/remainder so the caller can finish on the last step.
module ex_md_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem, quo, dvs;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   shifted, diff;

  // Dividend bits shift out of quo's top while quotient bits shift in at the bottom.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[XLEN]) begin
      remainder = diff[XLEN-1:0];
      quotient  = {quo[XLEN-2:0], 1'b1};
    end else begin
      remainder = shifted[XLEN-1:0];
      quotient  = {quo[XLEN-2:0], 1'b0};
    end
  end

  assign last = (cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (clear) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= '0;
    end else if (step) begin
      rem <= remainder;
      quo <= quotient;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide beside the EX ALU: stalls the front end while
// busy and releases one result strobe with its destination register.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [MD_OP_BUS-1:0] op_i,
  input  logic [XLEN-1:0]      reg1_i,
  input  logic [XLEN-1:0]      reg2_i,
  input  logic [4:0]           wd_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic                 valid_o,
  output logic [XLEN-1:0]      result_o,
  output logic [4:0]           wd_o
);
  localparam int MUL_ITERS = XLEN / MUL_STEP;
  localparam int CW        = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state, state_nxt;

  logic [MD_OP_BUS-1:0] op;
  logic [4:0]           wd;
  logic                 neg_q, neg_r;
  logic [XLEN-1:0]      mag_a;
  logic [2*XLEN-1:0]    acc, acc_nxt, prod;
  logic [CW-1:0]        cnt;
  logic                 is_mul, last, div_last;
  logic [XLEN-1:0]      q_step, r_step, q_fix, r_fix, fin;

  // Accept-time decode of the incoming op
  logic            in_neg_a, in_neg_b, div0, ovf, special;
  logic [XLEN-1:0] in_mag_a, in_mag_b, special_res;

  always_comb begin
    in_neg_a = rs1_signed(op_i) & reg1_i[XLEN-1];
    in_neg_b = rs2_signed(op_i) & reg2_i[XLEN-1];
    in_mag_a = in_neg_a ? -reg1_i : reg1_i;
    in_mag_b = in_neg_b ? -reg2_i : reg2_i;
    div0     = op_i[2] && (reg2_i == '0);
    ovf      = ((op_i == MD_DIV) || (op_i == MD_REM)) && (reg1_i == MOST_NEG) && (&reg2_i);
    special  = div0 || ovf;
    if (op_i[1]) special_res = div0 ? reg1_i : '0;
    else         special_res = div0 ? '1 : MOST_NEG;
  end

  // Shift-add: add mag_a * low digit to the upper half, then shift the pair right.
  logic [XLEN+MUL_STEP-1:0]   psum;
  logic [2*XLEN+MUL_STEP-1:0] wide;
  always_comb begin
    psum    = (XLEN+MUL_STEP)'(acc[2*XLEN-1:XLEN])
            + (XLEN+MUL_STEP)'(mag_a) * (XLEN+MUL_STEP)'(acc[MUL_STEP-1:0]);
    wide    = {psum, acc[XLEN-1:0]};
    acc_nxt = wide[2*XLEN+MUL_STEP-1:MUL_STEP];
  end

  ex_md_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .clear     (rst | flush_i),
    .load      (state == MD_IDLE && start_i && !flush_i),
    .step      (state == MD_BUSY && !is_mul),
    .dividend  (in_mag_a),
    .divisor   (in_mag_b),
    .quotient  (q_step),
    .remainder (r_step),
    .last      (div_last)
  );

  assign is_mul = !op[2];
  assign last   = is_mul ? (cnt == CW'(MUL_ITERS-1)) : div_last;

  always_comb begin
    prod  = neg_q ? -acc_nxt : acc_nxt;
    q_fix = neg_q ? -q_step : q_step;
    r_fix = neg_r ? -r_step : r_step;
    if (is_mul) fin = (op == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else        fin = op[1] ? r_fix : q_fix;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start_i) state_nxt = special ? MD_DONE : MD_BUSY;
      MD_BUSY: if (last) state_nxt = MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    if (flush_i) state_nxt = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      op       <= MD_MUL;
      wd       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mag_a    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_o <= '0;
      wd_o     <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start_i) begin
          op    <= op_i;
          wd    <= wd_i;
          neg_q <= in_neg_a ^ in_neg_b;
          neg_r <= in_neg_a;
          mag_a <= in_mag_a;
          acc   <= {{XLEN{1'b0}}, in_mag_b};
          cnt   <= '0;
          if (special) begin
            result_o <= special_res;
            wd_o     <= wd_i;
          end
        end
        MD_BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            result_o <= fin;
            wd_o     <= wd;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o = !rst && !flush_i &&
                   ((state == MD_IDLE && start_i) || state == MD_BUSY);
  assign valid_o = (state == MD_DONE) && !flush_i;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multi-cycle RV32M multiply/divide unit that sits beside the combinational execute ALU in the EX stage.
- Accepts one M-extension operation, asserts a stall to freeze the IF/ID/EX pipeline registers, and returns the result with its destination register for the EX/MEM write path.
- Parametrised in operand width and multiply radix.
- Adds the corner-case semantics for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width in bits; must be even and at least 8.
- MUL_STEP, 1, multiplier bits retired per cycle; must divide XLEN evenly (1, 2, 4, 8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  valid M-extension op present in EX this cycle.
- op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- reg1_i  in  XLEN  rs1 operand (multiplicand/dividend).
- reg2_i  in  XLEN  rs2 operand (multiplier/divisor).
- wd_i  in  5  destination register address.
- flush_i  in  1  pipeline flush (branch/jump redirect); kills any in-flight op.
- stall_o  out  1  freeze request to the pipeline control.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  result, valid only while valid_o is high.
- wd_o  out  5  destination register of result_o.

Behaviour:
- States: IDLE, BUSY, DONE. Reset and flush_i both force IDLE on the next edge, clear the iteration counter, and drive valid_o=0, result_o=0, wd_o=0.
- stall_o is combinational:
  - high when (IDLE and start_i and not flush_i), or when in BUSY;
  - low in DONE, low while rst is high, low while flush_i is high.
- IDLE, start_i=1, no flush:
  - latch op_i and wd_i;
  - latch operand magnitudes plus sign flags (signed for MULH/DIV/REM; rs1 only for MULHSU);
  - go to BUSY, or go straight to DONE for a special case.
- Special cases, resolved at accept (DONE on the next cycle, so latency is 1):
  - DIV/DIVU with divisor 0: quotient all-ones.
  - REM/REMU with divisor 0: result = dividend.
  - DIV with dividend = most-negative and divisor = -1: result = most-negative.
  - REM with dividend = most-negative and divisor = -1: result = 0.
- BUSY, multiply: shift-add, MUL_STEP bits per cycle, 2*XLEN-bit unsigned accumulator, XLEN/MUL_STEP cycles.
- BUSY, divide: restoring divide, 1 quotient bit per cycle, XLEN cycles.
- BUSY exit: on the last iteration, apply sign correction, register result_o and wd_o, and go to DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the dividend's sign.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DONE: valid_o=1 for exactly one cycle, then IDLE unconditionally. start_i is ignored in DONE because it is the same instruction being released; a new op can be accepted on the following cycle.
- Latency, with accept at cycle T:
  - valid_o at T+1+XLEN/MUL_STEP for multiply;
  - valid_o at T+1+XLEN for divide;
  - valid_o at T+1 for special cases.
- start_i in BUSY is ignored. Operand inputs may change after accept without effect.
- flush_i in DONE suppresses valid_o in that same cycle.
- All arithmetic is unsigned on magnitudes; no X propagation; no result when start_i=0.

Decomposition:
- Shared package (added to defines.v) holds:
  - MD_MUL..MD_REMU funct3 constants;
  - state encodings MD_IDLE/MD_BUSY/MD_DONE;
  - an MD_OpBus width macro.
- One natural sub-module: ex_md_divider, the restoring-divide datapath (remainder/quotient registers, step, count). Multiply, sign handling, FSM and outputs stay in ex_muldiv.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), MUL_STEP=1: stall_o high for cycles T..T+32; valid_o at T+33 with result 0xFFFFFFEB and wd_o echoed.
- Multiply high variants:
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH same operands → 0x00000000.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
  - Repeat with MUL_STEP=4: valid_o at T+9.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. valid_o at T+33. DIVU 100/7 → 14; REMU → 2.
- Corner cases:
  - DIV x/0 → 0xFFFFFFFF.
  - REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - All at T+1 with a single stall cycle.
- Flush mid-divide at cycle T+10: stall_o drops the same cycle, no valid_o ever appears for that op, and a following MUL 3×5 → 15 completes normally.
- Synchronous rst asserted during BUSY: next edge is IDLE, outputs zero, stall_o low; a held start_i after rst releases is accepted fresh. Back-to-back ops with start_i held high through DONE produce exactly one valid_o each.
